// File: rtl/receiver_pkg.sv
// receiver_pkg: shared types and defaults for the receive demodulator.
//   rx_state_t    framing FSM states (IDLE, HUNT, LEN, DATA, CHECK)
//   SYNC_WORD_DEF default frame sync pattern (sent MSB first)
//   MIDPOINT_DEF  default ADC code taken as the zero level
//   acc_width()   integrator width: 9-bit centred sample plus growth for
//                 the number of samples summed per symbol
package receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    LEN,
    DATA,
    CHECK
  } rx_state_t;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hD3;
  localparam logic [7:0] MIDPOINT_DEF  = 8'h80;

  function automatic int acc_width(input int symbol_cycles);
    return 9 + $clog2(symbol_cycles);
  endfunction

endpackage

// File: rtl/symbol_integrator.sv
// symbol_integrator: integrate-and-dump bit recovery from an unsigned ADC.
// Parameters: SYMBOL_CYCLES (clocks per bit, >= 2), MIDPOINT (zero level).
// Ports:
//   clock    in   system clock
//   resetN   in   asynchronous active-low reset
//   enable   in   receive enable; while low the symbol counter and the
//                 accumulator are held at 0, so the first enabled clock is
//                 always sample 0 of a symbol
//   ad       in   8-bit unsigned ADC sample
//   bit_val  out  decided bit (valid with bit_stb)
//   bit_stb  out  one-clock strobe, the clock after the last symbol sample
module symbol_integrator
  import receiver_pkg::*;
#(
  parameter int         SYMBOL_CYCLES = 16,
  parameter logic [7:0] MIDPOINT      = MIDPOINT_DEF
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       enable,
  input  logic [7:0] ad,
  output logic       bit_val,
  output logic       bit_stb
);

  localparam int AW = acc_width(SYMBOL_CYCLES);
  localparam int CW = $clog2(SYMBOL_CYCLES);

  logic        [CW-1:0] sym_cnt_p0;
  logic signed [AW-1:0] acc_p0;
  logic signed [8:0]    sample_c;
  logic signed [AW-1:0] acc_next;
  logic                 sym_last;
  logic                 bit_p1;
  logic                 vld_p1;

  function automatic logic signed [8:0] centre(input logic [7:0] s);
    return $signed({1'b0, s}) - $signed({1'b0, MIDPOINT});
  endfunction

  // A non-negative sum decides 1, so a window sitting exactly on the
  // midpoint reads as a 1.
  function automatic logic decide(input logic signed [AW-1:0] a);
    return ~a[AW-1];
  endfunction

  always_comb begin
    sample_c = centre(ad);
    acc_next = acc_p0 + $signed({{(AW-9){sample_c[8]}}, sample_c});
    sym_last = (sym_cnt_p0 == CW'(SYMBOL_CYCLES - 1));
  end

  // p0: symbol counter and running sum; p1: decided bit and its strobe
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sym_cnt_p0 <= '0;
      acc_p0     <= '0;
      bit_p1     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (!enable) begin
        sym_cnt_p0 <= '0;
        acc_p0     <= '0;
      end else if (sym_last) begin
        sym_cnt_p0 <= '0;
        acc_p0     <= '0;
        bit_p1     <= decide(acc_next);
        vld_p1     <= 1'b1;
      end else begin
        sym_cnt_p0 <= sym_cnt_p0 + 1'b1;
        acc_p0     <= acc_next;
      end
    end
  end

  assign bit_val = bit_p1;
  assign bit_stb = vld_p1;

endmodule

// File: rtl/receiver_demod.sv
// receiver_demod: receive datapath. Recovers bits from the ADC by
// integrate-and-dump, hunts for the sync word, de-frames length + payload
// (+ trailing XOR checksum) and hands payload bytes out on a one-entry
// valid/ready holding register.
// Build option: RECEIVER_DEMOD_CHECKSUM_EN adds the checksum byte and the
// CHECK state; without it a frame completes on its last payload byte.
// Ports:
//   clock              in   system clock
//   resetN             in   asynchronous active-low reset
//   receiver_sync_in   in   receive enable; rising edge aligns symbol timing,
//                           low discards any partial frame
//   receiver_sync_out  out  frame lock (FSM in LEN/DATA/CHECK)
//   receiver_ad        in   8-bit unsigned ADC sample
//   out_data           out  payload byte
//   out_valid          out  out_data valid
//   out_ready          in   downstream accepts out_data
//   out_last           out  marks the final payload byte of a frame
//   frame_ok           out  one-clock pulse: frame completed good
//   frame_err          out  one-clock pulse: frame rejected or corrupted
module receiver_demod
  import receiver_pkg::*;
#(
  parameter int         SYMBOL_CYCLES = 16,
  parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] MIDPOINT      = MIDPOINT_DEF
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       receiver_sync_in,
  output logic       receiver_sync_out,
  input  logic [7:0] receiver_ad,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err
);

  logic       bit_val;
  logic       bit_stb;

  rx_state_t  state;
  // Only the previous seven bits are kept; the incoming bit completes the byte.
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] remaining;
  logic       ovf;
`ifdef RECEIVER_DEMOD_CHECKSUM_EN
  logic [7:0] chk;
`endif

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       reg_full;
  logic       last_byte;
  logic       load;
  logic       drop;

  symbol_integrator #(
    .SYMBOL_CYCLES (SYMBOL_CYCLES),
    .MIDPOINT      (MIDPOINT)
  ) u_integrator (
    .clock   (clock),
    .resetN  (resetN),
    .enable  (receiver_sync_in),
    .ad      (receiver_ad),
    .bit_val (bit_val),
    .bit_stb (bit_stb)
  );

  assign rx_byte   = {sr, bit_val};
  assign byte_done = receiver_sync_in && bit_stb && (bit_cnt == 3'd7);
  // A byte accepted this cycle frees the register for a byte landing now.
  assign reg_full  = out_valid && !out_ready;
  assign last_byte = (remaining == 8'd1);
  assign load      = (state == DATA) && byte_done && !reg_full;
  assign drop      = (state == DATA) && byte_done && reg_full;

  assign receiver_sync_out = (state == LEN) || (state == DATA) || (state == CHECK);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
`ifdef RECEIVER_DEMOD_CHECKSUM_EN
      chk       <= '0;
`endif
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (!receiver_sync_in) begin
        // Losing the enable abandons the frame silently.
        state   <= IDLE;
        sr      <= '0;
        bit_cnt <= '0;
      end else begin
        if (bit_stb && (state != IDLE)) begin
          sr      <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          IDLE: state <= HUNT;
          HUNT: begin
            // Sliding match on every bit, no byte alignment.
            if (bit_stb && (rx_byte == SYNC_WORD)) begin
              state   <= LEN;
              bit_cnt <= '0;
              ovf     <= 1'b0;
            end
          end
          LEN: begin
            if (byte_done) begin
              if ((rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN))) begin
                frame_err <= 1'b1;
                state     <= HUNT;
              end else begin
                state     <= DATA;
                remaining <= rx_byte;
`ifdef RECEIVER_DEMOD_CHECKSUM_EN
                chk       <= '0;
`endif
              end
            end
          end
          DATA: begin
            if (byte_done) begin
              remaining <= remaining - 8'd1;
`ifdef RECEIVER_DEMOD_CHECKSUM_EN
              chk <= chk ^ rx_byte;
`endif
              if (drop) ovf <= 1'b1;
              if (last_byte) begin
`ifdef RECEIVER_DEMOD_CHECKSUM_EN
                state <= CHECK;
`else
                state <= HUNT;
                if (ovf || drop) frame_err <= 1'b1;
                else             frame_ok  <= 1'b1;
`endif
              end
            end
          end
`ifdef RECEIVER_DEMOD_CHECKSUM_EN
          CHECK: begin
            if (byte_done) begin
              state <= HUNT;
              if ((rx_byte == chk) && !ovf) frame_ok  <= 1'b1;
              else                          frame_err <= 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  // One-entry holding register; a load in the accept cycle keeps it valid.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= rx_byte;
      out_valid <= 1'b1;
      out_last  <= last_byte;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: doc/receiver_demod.md
Name: receiver_demod

Overview:
- Receive-side counterpart of the sender datapath.
- Samples the 8-bit channel ADC and recovers bits by integrate-and-dump over fixed symbol windows.
- Hunts for a sync word, then de-frames length + payload (+ optional checksum).
- Delivers payload bytes on a valid/ready byte stream to downstream logic, and flags frame lock on receiver_sync_out.

Parameters:
- SYMBOL_CYCLES, 16, clocks per bit; integration window length (>=2).
- SYNC_WORD, 8'hD3, frame sync pattern, MSB first.
- MAX_LEN, 16, maximum legal payload length in bytes (1..255).
- MIDPOINT, 8'h80, ADC code treated as zero level.

Ports:
- clock  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- receiver_sync_in  in  1  receive enable; rising edge aligns the symbol counter
- receiver_sync_out  out  1  frame lock: high while in LEN/DATA/CHECK
- receiver_ad  in  8  ADC sample, unsigned
- out_data  out  8  recovered payload byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- out_last  out  1  qualifies last payload byte of the frame
- frame_ok  out  1  one-clock pulse: frame completed good
- frame_err  out  1  one-clock pulse: frame rejected or corrupted

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low (resetN). All outputs reset to 0, FSM to IDLE, accumulators and shift registers to 0.
- Symbol timing:
  - Counter sym_cnt runs 0..SYMBOL_CYCLES-1. It is cleared on the rising edge of receiver_sync_in and held at 0 while receiver_sync_in is low.
  - Accumulator acc is signed, width 9+clog2(SYMBOL_CYCLES). Each clock: acc += receiver_ad - MIDPOINT (sign-extended).
  - When sym_cnt == SYMBOL_CYCLES-1, the bit is decided: bit = (acc_next >= 0). acc then reloads to 0. A bit_stb pulse is issued one clock later.
  - An exact-midpoint input decides 1.
- Bit order: MSB first. Bits shift into an 8-bit shift register sr.
- FSM (advances on bit_stb only, except IDLE exit):
  - IDLE: entered when receiver_sync_in is low; goes to HUNT when it is high.
  - HUNT: on every bit, if {sr[6:0],bit} == SYNC_WORD, go to LEN and clear the bit counter. Sliding match, no byte alignment.
  - LEN: after 8 bits, len = byte. If len == 0 or len > MAX_LEN: pulse frame_err and return to HUNT. Otherwise go to DATA with remaining = len and chk = 0.
  - DATA: each completed byte is pushed to the holding register and XORed into chk. When remaining reaches 0, go to CHECK.
  - CHECK: after 8 bits, pulse frame_ok if byte == chk and no overflow occurred in this frame, else pulse frame_err. Return to HUNT.
- Output holding register (1 entry):
  - out_valid rises the clock after the byte completes.
  - The byte is accepted when out_valid && out_ready; out_valid drops the next clock unless a new byte is loaded in the same cycle.
  - out_last is set with the final payload byte.
  - If a byte completes while the register is still full, that byte is dropped, an overflow flag is set, and the frame ends in frame_err.
- receiver_sync_in falling mid-frame: FSM goes to IDLE next clock. The partial frame is discarded with no pulses. A byte already held stays valid until accepted (handshake is never retracted).
- frame_ok and frame_err are never asserted in the same cycle.

Optional Feature:
- Macro: RECEIVER_DEMOD_CHECKSUM_EN.
- Defined: trailing XOR checksum byte is received and checked in CHECK, as described above.
- Undefined: the CHECK state and chk register are removed. frame_ok pulses on the clock the last payload byte is loaded, unless overflow occurred, in which case frame_err pulses instead.

Decomposition:
- Shared package receiver_pkg: FSM state enum (IDLE, HUNT, LEN, DATA, CHECK), default SYNC_WORD, MIDPOINT, and the acc width function.
- One sub-module, symbol_integrator: sym_cnt, acc, bit decision, and bit/bit_stb output. Framing FSM and output register stay in the top module.

Test Plan:
- Common setup: SYMBOL_CYCLES=4, checksum enabled. Bit 1 = ad 0xC0 for 4 clocks, bit 0 = 0x40.
- Frame D3,02,5A,3C,66 with out_ready=1 -> out_data 5A then 3C, out_last only on 3C. frame_ok one pulse after checksum. receiver_sync_out high from after D3 through checksum.
- Same frame with checksum 0x67 -> bytes 5A,3C still delivered, frame_err pulse, no frame_ok, FSM back in HUNT.
- Bits FF,FF,D3,00 -> sync found after D3 despite garbage; len 0 gives frame_err and receiver_sync_out back low.
- D3,02,11,22,33 with out_ready=0 -> 0x11 held valid, 0x22 dropped, frame_err after checksum. Raising out_ready then delivers 0x11 only.
- receiver_sync_in dropped during second payload byte -> IDLE next clock, receiver_sync_out low, no frame_ok/frame_err. Constant ad=0x80 after re-enable decodes all-1 bits.
- With RECEIVER_DEMOD_CHECKSUM_EN undefined: D3,01,A5 -> out A5 with out_last, frame_ok on the same clock out_valid rises.
